// File: rtl/wb_arb2.sv
// wb_arb2: two-master Wishbone arbiter sharing one slave port.
// Optional feature macro: WB_ARB2_RR_EN
//   defined   -> round-robin on simultaneous requests (master other than
//                the last grantee wins)
//   undefined -> fixed priority, m0 wins simultaneous requests
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no owner; slave port driven to zero, slave ack discarded
// ST_GNT0 | m0 owns the slave port until it drops m0_cyc_i
// ST_GNT1 | m1 owns the slave port until it drops m1_cyc_i
//
// The grant is registered, but the slave-side signals are a combinational
// mux of the owner's inputs. s_cyc_o therefore drops in the same cycle the
// owner releases, which guarantees a one-cycle gap before a handover.
module wb_arb2 #(
  parameter int adr_width = 32
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic [adr_width-1:0] m0_adr_i,
  input  logic [1:0]           m0_bte_i,
  input  logic [2:0]           m0_cti_i,
  input  logic [31:0]          m0_dat_i,
  input  logic [3:0]           m0_sel_i,
  input  logic                 m0_we_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  output logic [31:0]          m0_dat_o,
  output logic                 m0_ack_o,

  input  logic [adr_width-1:0] m1_adr_i,
  input  logic [1:0]           m1_bte_i,
  input  logic [2:0]           m1_cti_i,
  input  logic [31:0]          m1_dat_i,
  input  logic [3:0]           m1_sel_i,
  input  logic                 m1_we_i,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  output logic [31:0]          m1_dat_o,
  output logic                 m1_ack_o,

  output logic [adr_width-1:0] s_adr_o,
  output logic [1:0]           s_bte_o,
  output logic [2:0]           s_cti_o,
  output logic [31:0]          s_dat_o,
  output logic [3:0]           s_sel_o,
  output logic                 s_we_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  input  logic [31:0]          s_dat_i,
  input  logic                 s_ack_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  state_t r_state;
  logic   r_last_gnt;   // 0 = m0 granted most recently, 1 = m1
  logic   w_pick_m1;    // winner when both masters request from idle

  // Tie-break for simultaneous requests seen in idle.
  always_comb begin
`ifdef WB_ARB2_RR_EN
    w_pick_m1 = ~r_last_gnt;
`else
    // last_gnt is still tracked, but never decides the fixed-priority winner
    w_pick_m1 = r_last_gnt & 1'b0;
`endif
  end

  // Grant state machine and last-grantee record; reset aborts any cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            if (w_pick_m1) begin
              r_state    <= ST_GNT1;
              r_last_gnt <= 1'b1;
            end else begin
              r_state    <= ST_GNT0;
              r_last_gnt <= 1'b0;
            end
          end else if (m0_cyc_i) begin
            r_state    <= ST_GNT0;
            r_last_gnt <= 1'b0;
          end else if (m1_cyc_i) begin
            r_state    <= ST_GNT1;
            r_last_gnt <= 1'b1;
          end
        end
        ST_GNT0: begin
          if (!m0_cyc_i) begin
            if (m1_cyc_i) begin
              r_state    <= ST_GNT1;
              r_last_gnt <= 1'b1;
            end else begin
              r_state    <= ST_IDLE;
            end
          end
        end
        ST_GNT1: begin
          if (!m1_cyc_i) begin
            if (m0_cyc_i) begin
              r_state    <= ST_GNT0;
              r_last_gnt <= 1'b0;
            end else begin
              r_state    <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Slave-port mux and ack steering, driven by the registered grant.
  always_comb begin
    s_adr_o  = '0;
    s_bte_o  = '0;
    s_cti_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    case (r_state)
      ST_GNT0: begin
        s_adr_o  = m0_adr_i;
        s_bte_o  = m0_bte_i;
        s_cti_o  = m0_cti_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        m0_ack_o = s_ack_i;
      end
      ST_GNT1: begin
        s_adr_o  = m1_adr_i;
        s_bte_o  = m1_bte_i;
        s_cti_o  = m1_cti_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        m1_ack_o = s_ack_i;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arb2.sv
// Directed bench for wb_arb2 with a zero-wait-state memory slave.
// Build with or without WB_ARB2_RR_EN; arbitration expectations follow it.
module tb_wb_arb2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i;
  logic [1:0]  m0_bte_i, m1_bte_i;
  logic [2:0]  m0_cti_i, m1_cti_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [1:0]  s_bte_o;
  logic [2:0]  s_cti_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;

  logic        slave_en, ack_force;
  logic [31:0] mem [0:1023];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  wb_arb2 #(.adr_width(32)) dut (
    .clk(clk), .reset(reset),
    .m0_adr_i(m0_adr_i), .m0_bte_i(m0_bte_i), .m0_cti_i(m0_cti_i),
    .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o),
    .m1_adr_i(m1_adr_i), .m1_bte_i(m1_bte_i), .m1_cti_i(m1_cti_i),
    .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o),
    .s_adr_o(s_adr_o), .s_bte_o(s_bte_o), .s_cti_o(s_cti_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i)
  );

  // zero-wait slave: acks any strobe in the same cycle
  assign s_ack_i = (slave_en & s_cyc_o & s_stb_o) | ack_force;
  assign s_dat_i = mem[s_adr_o[11:2]];

  always @(posedge clk)
    if (s_cyc_o && s_stb_o && s_we_o && s_ack_i)
      mem[s_adr_o[11:2]] <= s_dat_o;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat,
                        input logic [2:0] cti, input logic [1:0] bte);
    m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr;
    m0_dat_i = dat; m0_cti_i = cti; m0_bte_i = bte; m0_sel_i = 4'hF;
    #1;
  endtask

  task automatic set_m1(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat,
                        input logic [2:0] cti, input logic [1:0] bte);
    m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr;
    m1_dat_i = dat; m1_cti_i = cti; m1_bte_i = bte; m1_sel_i = 4'hF;
    #1;
  endtask

  logic [1:0] exp_win [0:2];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
`ifdef WB_ARB2_RR_EN
    exp_win[0] = 2'd0; exp_win[1] = 2'd1; exp_win[2] = 2'd0;
`else
    exp_win[0] = 2'd0; exp_win[1] = 2'd0; exp_win[2] = 2'd0;
`endif
    slave_en = 1'b1; ack_force = 1'b0;
    reset = 1'b1;
    set_m1(0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    // a request held during reset must not be granted
    set_m0(1, 1, 1, 32'h55, 32'hDEAD_BEEF, 3'b000, 2'b00);
    tick(); tick();
    chk("rst_cyc", s_cyc_o, 0);
    chk("rst_adr", s_adr_o, 0);
    chk("rst_dat", s_dat_o, 0);
    chk("rst_ack0", m0_ack_o, 0);
    set_m0(0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    reset = 1'b0;
    tick();

    // classic write then read of 0x100 by m0
    set_m0(1, 1, 1, 32'h100, 32'h1234_5678, 3'b000, 2'b00);
    chk("wr_latency", s_cyc_o, 0);
    tick();
    chk("wr_cyc", s_cyc_o, 1);
    chk("wr_adr", s_adr_o, 32'h100);
    chk("wr_dat", s_dat_o, 32'h1234_5678);
    chk("wr_ack0", m0_ack_o, 1);
    chk("wr_ack1", m1_ack_o, 0);
    tick();
    set_m0(0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    chk("wr_release", s_cyc_o, 0);
    tick();
    set_m0(1, 1, 0, 32'h100, 32'h0, 3'b000, 2'b00);
    chk("rd_latency", s_cyc_o, 0);
    tick();
    chk("rd_cyc", s_cyc_o, 1);
    chk("rd_ack0", m0_ack_o, 1);
    chk("rd_data", m0_dat_o, 32'h1234_5678);
    chk("rd_ack1", m1_ack_o, 0);
    tick();
    set_m0(0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    tick();

    // m0 beat4 write burst; m1 requests at beat 2 and must wait
    set_m0(1, 1, 1, 32'hA000, 32'hB000_0000, 3'b010, 2'b01);
    tick();
    for (int b = 0; b < 4; b++) begin
      set_m0(1, 1, 1, 32'hA000 + 32'(b * 4), 32'hB000_0000 + 32'(b),
             (b == 3) ? 3'b111 : 3'b010, 2'b01);
      if (b == 1) set_m1(1, 1, 0, 32'hB000, 32'h0, 3'b000, 2'b00);
      chk($sformatf("burst_adr%0d", b), s_adr_o, 32'hA000 + 32'(b * 4));
      chk($sformatf("burst_ack0_%0d", b), m0_ack_o, 1);
      if (b >= 1) chk($sformatf("burst_ack1_%0d", b), m1_ack_o, 0);
      tick();
    end
    chk("burst_mem3", mem[3], 32'hB000_0003);
    set_m0(0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    chk("handover_gap", s_cyc_o, 0);
    chk("handover_gap_ack1", m1_ack_o, 0);
    tick();
    chk("handover_cyc", s_cyc_o, 1);
    chk("handover_adr", s_adr_o, 32'hB000);
    chk("handover_ack1", m1_ack_o, 1);
    chk("handover_ack0", m0_ack_o, 0);
    set_m1(0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    tick();

    // three simultaneous requests directly after reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int r = 0; r < 3; r++) begin
      set_m0(1, 1, 0, 32'h10, 32'h0, 3'b000, 2'b00);
      set_m1(1, 1, 0, 32'h20, 32'h0, 3'b000, 2'b00);
      tick();
      chk($sformatf("arb%0d_adr", r), s_adr_o, (exp_win[r] == 2'd0) ? 32'h10 : 32'h20);
      chk($sformatf("arb%0d_ack0", r), m0_ack_o, (exp_win[r] == 2'd0) ? 1 : 0);
      chk($sformatf("arb%0d_ack1", r), m1_ack_o, (exp_win[r] == 2'd1) ? 1 : 0);
      set_m0(0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
      set_m1(0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
      tick();
    end

    // reset in the middle of an m1 beat4 read
    set_m1(1, 1, 0, 32'h200, 32'h0, 3'b010, 2'b01);
    tick();
    chk("m1rd_beat1", m1_ack_o, 1);
    tick();
    set_m1(1, 1, 0, 32'h204, 32'h0, 3'b010, 2'b01);
    reset = 1'b1;
    tick();
    chk("rstmid_cyc", s_cyc_o, 0);
    chk("rstmid_ack1", m1_ack_o, 0);
    chk("rstmid_adr", s_adr_o, 0);
    reset = 1'b0;
    set_m1(0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    tick();
    set_m1(1, 1, 0, 32'h300, 32'h0, 3'b000, 2'b00);
    chk("rerq_latency", s_cyc_o, 0);
    tick();
    chk("rerq_cyc", s_cyc_o, 1);
    chk("rerq_adr", s_adr_o, 32'h300);
    chk("rerq_ack1", m1_ack_o, 1);
    set_m1(0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    tick();

    // stray slave ack while idle, coinciding with a fresh m0 request
    slave_en = 1'b0;
    ack_force = 1'b1;
    set_m0(1, 1, 0, 32'h40, 32'h0, 3'b000, 2'b00);
    chk("idle_ack0", m0_ack_o, 0);
    chk("idle_ack1", m1_ack_o, 0);
    chk("idle_cyc", s_cyc_o, 0);
    tick();
    ack_force = 1'b0;
    slave_en = 1'b1;
    #1;
    chk("idle_then_gnt", s_cyc_o, 1);
    chk("idle_then_adr", s_adr_o, 32'h40);
    set_m0(0, 0, 0, 32'h0, 32'h0, 3'b000, 2'b00);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arb2.md
WB_ARB2 -- requirements
Module: wb_arb2

Interface
REQ-001 Parameter adr_width, 32, address width of both master ports and the slave port.
REQ-002 Port clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 Port reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Ports m0_adr_i / m1_adr_i  in  adr_width  master byte address.
REQ-005 Ports m0_bte_i / m1_bte_i  in  2  burst type extension (linear, beat4, beat8, beat16).
REQ-006 Ports m0_cti_i / m1_cti_i  in  3  cycle type (classic 000, incrementing 010, end-of-burst 111).
REQ-007 Ports m0_dat_i / m1_dat_i  in  32  master write data.
REQ-008 Ports m0_sel_i / m1_sel_i  in  4  byte selects.
REQ-009 Ports m0_we_i, m0_cyc_i, m0_stb_i / m1_we_i, m1_cyc_i, m1_stb_i  in  1 each  write enable, cycle, strobe.
REQ-010 Ports m0_dat_o / m1_dat_o  out  32  read data, both driven from s_dat_i.
REQ-011 Ports m0_ack_o / m1_ack_o  out  1  acknowledge to that master.
REQ-012 Ports s_adr_o, s_bte_o, s_cti_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o  out  widths as master inputs  shared slave port.
REQ-013 Ports s_dat_i  in  32, s_ack_i  in  1  slave read data and acknowledge.

Function
REQ-014 FSM with states IDLE, GNT0, GNT1, held in a register; grant outputs are a combinational mux driven by the registered state.
REQ-015 IDLE: s_cyc_o=0, s_stb_o=0, s_we_o=0, s_adr_o/s_dat_o/s_sel_o/s_cti_o/s_bte_o=0, m0_ack_o=m1_ack_o=0.
REQ-016 GNTn: every s_*_o equals the corresponding mn_*_i in the same cycle; mn_ack_o=s_ack_i; the other master's ack_o=0.
REQ-017 IDLE -> GNTn on the clock edge where mn_cyc_i=1 and n wins arbitration; arbitration latency exactly one cycle (s_cyc_o rises the cycle after the winning m_cyc_i).
REQ-018 Grant is held while the owner's cyc_i=1, irrespective of cti (classic, inc, eob) and of stb_i gaps; no preemption mid-burst or between back-to-back transfers under one cyc.
REQ-019 On the edge where the owner's cyc_i=0: if the other master's cyc_i=1 go directly to its GNT state, else go to IDLE.
REQ-020 s_cyc_o follows the owner's cyc_i combinationally, so it is low for at least the one cycle in which the owner released, before the new owner is presented.
REQ-021 Register last_gnt records the most recently granted master, updated on every entry to GNT0/GNT1.
REQ-022 Simultaneous requests in IDLE: winner per REQ-030/REQ-031.
REQ-023 A master waiting while the other owns the bus sees ack_o=0 and holds its request; no request is dropped or queued beyond its live cyc_i.
REQ-024 s_ack_i in IDLE is ignored and reaches neither master.

Reset
REQ-025 reset=1 forces state to IDLE and last_gnt to 1 on the next rising clk, aborting any cycle in progress.
REQ-026 From the cycle after reset is sampled, all outputs take IDLE values (REQ-015).
REQ-027 While reset=1 no grant is issued, whatever cyc_i values are present.
REQ-028 After reset release, m0 wins the first simultaneous request.

Configuration
REQ-029 Macro WB_ARB2_RR_EN selects round-robin; absent, fixed priority.
REQ-030 Defined: on simultaneous requests the master other than last_gnt wins.
REQ-031 Undefined: m0 always wins simultaneous requests; last_gnt is still maintained but not used.

Verification
REQ-032 m0 classic write adr 0x100 data 0x12345678, then read adr 0x100 -> s_cyc_o rises one cycle after m0_cyc_i; m0 read returns 0x12345678; m1_ack_o stays 0.
REQ-033 m0 beat4 inc write burst 0xA000-0xA00C (eob on last) while m1 raises cyc at beat 2 -> m1 acks stay 0 until m0 drops cyc; s_adr_o shows 0xA000, 0xA004, 0xA008, 0xA00C contiguously; m1 granted on the next edge.
REQ-034 Both cyc_i rise in the same cycle directly after reset, three times in sequence with WB_ARB2_RR_EN -> grant order m0, m1, m0; without the macro -> m0, m0, m0.
REQ-035 reset asserted mid m1 beat4 read at beat 2 -> cycle after reset sampled: s_cyc_o=0, m1_ack_o=0, state IDLE; next m1 request is granted with one-cycle latency.
REQ-036 Slave asserts s_ack_i while IDLE -> m0_ack_o=m1_ack_o=0 and no state change.
